// File: rtl/dvl_readout_sequencer.sv
// DDR3-to-readout transfer window sequencer: arm, gate data_valid, count beats, holdoff, done.
// Optional watchdog on the VALID window enabled by defining DVL_TIMEOUT_EN.
module dvl_readout_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_BEATS   = 4096,
  parameter int unsigned HOLDOFF_CYC = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             abort_i,
  input  logic             ddr3_full_i,
  input  logic             fifo_full_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_rd_i,
  output logic             data_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] beat_count_o,
  output logic             limit_o,
  output logic             timeout_o
);

  localparam int unsigned HC_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  if (MAX_BEATS < 1 || 64'(MAX_BEATS) >= (64'd1 << CNT_W) ||
      HOLDOFF_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("dvl_readout_sequencer: invalid parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_VALID   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              dv_q, dv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              limit_q, limit_d;

`ifdef DVL_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_q, timeout_d;
`endif

  // Next-state, counters and registered output values
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    beat_cnt_d = beat_cnt_q;
    limit_d    = limit_q;
`ifdef DVL_TIMEOUT_EN
    wd_d       = wd_q;
    timeout_d  = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable_i && !abort_i) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (fifo_full_i && ddr3_full_i) begin
          state_d    = ST_VALID;
          beat_cnt_d = '0;
          limit_d    = 1'b0;
`ifdef DVL_TIMEOUT_EN
          wd_d       = '0;
          timeout_d  = 1'b0;
`endif
        end else if (!enable_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_VALID: begin
        // A read is counted whenever the gate is open, including the closing cycle
        if (fifo_rd_i && beat_cnt_q != CNT_W'(MAX_BEATS)) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        hold_cnt_d = '0;
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (fifo_rd_i && beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
          state_d = ST_HOLDOFF;
          limit_d = 1'b1;
        end else if (fifo_empty_i) begin
          state_d = ST_HOLDOFF;
`ifdef DVL_TIMEOUT_EN
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          state_d   = ST_HOLDOFF;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
`endif
        end
      end
      ST_HOLDOFF: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HC_W'(HOLDOFF_CYC - 1)) begin
          state_d = enable_i ? ST_ARMED : ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    dv_d   = (state_d == ST_VALID);
    busy_d = (state_d != ST_IDLE);
    // done is registered so it shows during the final holdoff cycle
    done_d = (state_d == ST_HOLDOFF) && (hold_cnt_d == HC_W'(HOLDOFF_CYC - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      beat_cnt_q <= '0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      limit_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      limit_q    <= limit_d;
    end
  end

`ifdef DVL_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign data_valid_o = dv_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign beat_count_o = beat_cnt_q;
  assign limit_o      = limit_q;

endmodule
